data_mem_lsu: RTL and testbench
===============================

# data_mem_lsu

Parametrised byte-addressed data memory for the multi-cycle and pipelined cores. It replaces the word-indexed, combinational-read data memory. It adds sub-word loads and stores (byte and half, signed and unsigned), a valid/ready request handshake with a registered one-cycle response, alignment and range fault reporting, and a post-reset clearing sweep so memory contents are deterministic.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two, 4..65536
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for word and stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response for the request accepted on the previous edge
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  request was misaligned, out of range, or reserved size

## Operation
- States: INIT and RUN. Reset forces INIT with sweep index 0.
- INIT:
  - One word is written to 0 per cycle, indices 0..DEPTH-1.
  - req_ready=0. Requests are ignored and not stored.
  - After the index DEPTH-1 write, the block moves to RUN.
- RUN: req_ready=1 constantly. A request is accepted when req_valid and req_ready are both 1.
- Offset computation: off = req_addr - BASE_ADDR (32-bit, wraps). Word index = off[31:2]. Lane = off[1:0].
- Fault conditions (any one is sufficient):
  - size 11
  - half with lane[0]=1
  - word with lane!=0
  - index >= DEPTH, which includes req_addr below BASE_ADDR via wrap
- Faulting request: memory is unchanged, rsp_fault=1, rsp_rdata=0.
- Store behaviour:
  - Only the addressed lanes are written. Other bytes of the word are preserved.
  - Byte: lane k gets wdata[7:0].
  - Half: lanes k and k+1 get wdata[15:0].
  - Word: all lanes are written.
  - The write commits on the acceptance edge.
  - Response: rsp_valid=1, rsp_rdata=0, rsp_fault=0.
- Load behaviour:
  - The word is read at the acceptance edge. The addressed lanes are shifted to bit 0 and extended per req_unsigned.
- Every accepted request produces exactly one response. There is no response backpressure.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0, state INIT, sweep index 0.
- INIT duration: the first edge with reset=0 clears index 0. req_ready=1 in the cycle after the DEPTH-th such edge, i.e. DEPTH cycles after reset deasserts.
- Latency:
  - Request accepted at edge N produces response outputs valid from edge N to edge N+1.
  - rsp_valid is 0 in any cycle whose preceding edge accepted nothing.
- Throughput: one request per cycle, back-to-back.
- Read-after-write: a store accepted at N followed by a load of the same word at N+1 returns the new data. Same-edge conflicts cannot occur (single port).
- Reset mid-operation:
  - The pending response is dropped: rsp_valid=0 on the next edge.
  - The state restarts INIT from index 0.
  - Contents are cleared again.

## Structure
- Shared package data_mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD
  - the state enum (ST_INIT, ST_RUN)
- Sub-module lsu_lane_align is purely combinational and performs:
  - store lane merge (old word, wdata, size, lane) -> new word
  - load extract and extend (word, size, lane, unsigned) -> rdata
  - the misalignment check
- Top level holds the array, the FSM, the sweep counter, and the response registers.

## Test plan
- Reset init, DEPTH=16:
  - Hold reset 3 cycles, then release.
  - req_ready must rise exactly 16 cycles later.
  - A load of word 5 must return 0.
  - Requests during INIT produce no response.
- Byte store and extended load:
  - SW 0xAABBCCDD at 0x10, then SB 0x80 at 0x11.
  - LW 0x10 -> 0xAABB80DD.
  - LB 0x11 -> 0xFFFFFF80.
  - LBU 0x11 -> 0x00000080.
- Half access and misalignment:
  - SH 0x8001 at 0x22, then LH 0x22 -> 0xFFFF8001 and LHU -> 0x00008001.
  - LH 0x23 -> fault=1, rdata=0.
  - SW at 0x22 -> fault=1 and memory unchanged.
- Range and base, BASE_ADDR=0x1000, DEPTH=16:
  - LW 0x103C accepted, no fault.
  - LW 0x1040 -> fault.
  - LW 0x0FFC -> fault.
- Back-to-back:
  - SW 0x12345678 at 0x8, then LW 0x8 in the next cycle -> 0x12345678.
  - rsp_valid high for 2 consecutive cycles.
- Mid-run reset:
  - Assert reset the cycle after a load is accepted.
  - No response appears.
  - INIT re-runs.
  - The previously written word reads 0 afterward.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared encodings for the byte-addressed data memory: access sizes and controller states.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store merge into an existing word, load extract/extend,
// and the size/alignment fault check.
module lsu_lane_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o,
  output logic        align_fault_o
);

  logic [31:0] shifted;

  always_comb begin
    align_fault_o = 1'b0;
    merged_o      = word_i;
    rdata_o       = 32'h0;
    shifted       = word_i >> {lane_i, 3'b000};
    unique case (size_i)
      SZ_BYTE: begin
        merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
        rdata_o = unsigned_i ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        align_fault_o = lane_i[0];
        // lane[1] alone selects the half; an odd lane is faulted and never committed
        merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        rdata_o = unsigned_i ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        align_fault_o = |lane_i;
        merged_o      = wdata_i;
        rdata_o       = word_i;
      end
      default: align_fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with valid/ready requests, registered one-cycle response,
// fault reporting and a post-reset clearing sweep.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_fault_q, rsp_fault_d;

  logic [31:0]   off;
  logic [29:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic          in_range;
  logic [31:0]   rd_word, merged, ld_data;
  logic          align_fault, fault, accept;
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the range test
  assign off      = req_addr - BASE_ADDR;
  assign word_idx = off[31:2];
  assign mem_idx  = word_idx[AW-1:0];
  assign in_range = ~|word_idx[29:AW];
  assign rd_word  = mem[mem_idx];

  lsu_lane_align u_align (
    .word_i       (rd_word),
    .wdata_i      (req_wdata),
    .size_i       (size_e'(req_size)),
    .lane_i       (off[1:0]),
    .unsigned_i   (req_unsigned),
    .merged_o     (merged),
    .rdata_o      (ld_data),
    .align_fault_o(align_fault)
  );

  assign req_ready = (state_q == ST_RUN);
  assign accept    = req_valid && req_ready;
  assign fault     = align_fault || !in_range;

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    mem_we      = 1'b0;
    mem_widx    = mem_idx;
    mem_wdata   = merged;
    rsp_valid_d = accept;
    rsp_rdata_d = 32'h0;
    rsp_fault_d = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_widx  = sweep_q;
        mem_wdata = 32'h0;
        if (sweep_q == AW'(DEPTH - 1)) state_d = ST_RUN;
        else                           sweep_d = sweep_q + AW'(1);
      end
      ST_RUN: begin
        if (accept) begin
          rsp_fault_d = fault;
          if (!fault) begin
            if (req_we) mem_we = 1'b1;
            else        rsp_rdata_d = ld_data;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_widx] <= mem_wdata;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: byte-array reference model, directed and random traffic.
module tb_data_mem_lsu;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk, reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;

  data_mem_lsu #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  mem_b [DEPTH*4];
  int          checks = 0;
  int          errors = 0;
  int          init_cnt = 0;
  logic        ready_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_fault(input logic [31:0] addr, input logic [1:0] size);
    logic [31:0] off;
    int nb;
    off = addr - BASE;
    if (size == 2'b11) return 1'b1;
    nb = 1 << size;
    if ((off & 32'(nb - 1)) != 0) return 1'b1;
    if ((off >> 2) >= 32'(DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns);
    logic [31:0] off, v;
    int nb;
    off = addr - BASE;
    nb  = 1 << size;
    v   = 32'h0;
    for (int i = 0; i < nb; i++) v = v | (32'(mem_b[off + 32'(i)]) << (8 * i));
    if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  // Drive one request; if the block is expected to take it, update the model and queue the response.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic use_lit, input logic [31:0] lit_rd, input logic lit_f);
    exp_t e;
    logic [31:0] off;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    if (ready_exp && !reset) begin
      off     = addr - BASE;
      e.fault = model_fault(addr, size);
      e.rdata = 32'h0;
      if (!e.fault) begin
        if (we) for (int i = 0; i < (1 << size); i++) mem_b[off + 32'(i)] = wdata[8*i +: 8];
        else e.rdata = model_load(addr, size, uns);
      end
      if (use_lit) begin
        e.rdata = lit_rd;
        e.fault = lit_f;
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic op(input logic we, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wdata);
    issue(we, size, uns, addr, wdata, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic opx(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rd, input logic f);
    issue(we, size, uns, addr, wdata, 1'b1, rd, f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int i;
    i = 0;
    while (!ready_exp && i < 4 * DEPTH) begin
      @(negedge clk);
      req_valid = 1'b0;
      i++;
    end
    if (!ready_exp) begin
      checks++;
      errors++;
      $display("FAIL init_timeout: ready model never rose after %0d cycles", i);
    end
  endtask

  // Monitor: ready model plus response scoreboard, sampled 1ns after each rising edge
  always @(posedge clk) begin : mon
    logic rst_s;
    exp_t e;
    rst_s = reset;
    #1;
    if (rst_s) begin
      init_cnt  = 0;
      ready_exp = 1'b0;
      for (int i = 0; i < DEPTH * 4; i++) mem_b[i] = 8'h00;
    end else if (init_cnt < DEPTH) begin
      init_cnt++;
      ready_exp = (init_cnt == DEPTH);
    end
    chk("req_ready", {31'h0, req_ready}, {31'h0, ready_exp});
    if (rst_s) begin
      chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("reset_rsp_rdata", rsp_rdata, 32'h0);
      chk("reset_rsp_fault", {31'h0, rsp_fault}, 32'h0);
      sb_q.delete();
    end else if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h fault=%b with nothing expected at %0t",
                 rsp_rdata, rsp_fault, $time);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_fault", {31'h0, rsp_fault}, {31'h0, e.fault});
      end
    end else if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_rsp: rsp_valid=0 but response rdata=%h fault=%b expected at %0t",
               e.rdata, e.fault, $time);
    end else begin
      chk("idle_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Requests during the clearing sweep are ignored
    op(1'b1, 2'b10, 1'b0, BASE + 32'h14, 32'hFFFF_FFFF);
    op(1'b0, 2'b10, 1'b0, BASE + 32'h14, 32'h0);
    op(1'b1, 2'b00, 1'b0, BASE + 32'h03, 32'h0000_0055);
    wait_ready();
    opx(1'b0, 2'b10, 1'b0, BASE + 32'h14, 32'h0, 32'h0, 1'b0);

    // Byte store into a word, signed/unsigned byte loads
    opx(1'b1, 2'b10, 1'b0, BASE + 32'h10, 32'hAABB_CCDD, 32'h0, 1'b0);
    opx(1'b1, 2'b00, 1'b0, BASE + 32'h11, 32'h0000_0080, 32'h0, 1'b0);
    opx(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0, 32'hAABB_80DD, 1'b0);
    opx(1'b0, 2'b00, 1'b0, BASE + 32'h11, 32'h0, 32'hFFFF_FF80, 1'b0);
    opx(1'b0, 2'b00, 1'b1, BASE + 32'h11, 32'h0, 32'h0000_0080, 1'b0);
    idle(1);

    // Halves and misalignment
    opx(1'b1, 2'b01, 1'b0, BASE + 32'h22, 32'h0000_8001, 32'h0, 1'b0);
    opx(1'b0, 2'b01, 1'b0, BASE + 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
    opx(1'b0, 2'b01, 1'b1, BASE + 32'h22, 32'h0, 32'h0000_8001, 1'b0);
    opx(1'b0, 2'b01, 1'b0, BASE + 32'h23, 32'h0, 32'h0, 1'b1);
    opx(1'b1, 2'b10, 1'b0, BASE + 32'h22, 32'hDEAD_BEEF, 32'h0, 1'b1);
    opx(1'b0, 2'b10, 1'b0, BASE + 32'h20, 32'h0, 32'h8001_0000, 1'b0);
    opx(1'b0, 2'b11, 1'b0, BASE + 32'h20, 32'h0, 32'h0, 1'b1);

    // Range edges around BASE
    opx(1'b0, 2'b10, 1'b0, 32'h0000_103C, 32'h0, 32'h0, 1'b0);
    opx(1'b0, 2'b10, 1'b0, 32'h0000_1040, 32'h0, 32'h0, 1'b1);
    opx(1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0, 32'h0, 1'b1);
    idle(2);

    // Back-to-back store then load of the same word
    opx(1'b1, 2'b10, 1'b0, BASE + 32'h08, 32'h1234_5678, 32'h0, 1'b0);
    opx(1'b0, 2'b10, 1'b0, BASE + 32'h08, 32'h0, 32'h1234_5678, 1'b0);
    idle(1);

    // Random traffic, including a few out-of-range and misaligned addresses
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              BASE - 32'h8 + 32'($urandom_range(0, 32'h50)), $urandom);
    end
    idle(1);

    // Reset the cycle after a load is accepted; contents must be cleared again
    opx(1'b1, 2'b10, 1'b0, BASE + 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0);
    opx(1'b0, 2'b10, 1'b0, BASE + 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    op(1'b0, 2'b10, 1'b0, BASE + 32'h30, 32'h0);
    wait_ready();
    opx(1'b0, 2'b10, 1'b0, BASE + 32'h30, 32'h0, 32'h0, 1'b0);
    opx(1'b0, 2'b10, 1'b0, BASE + 32'h08, 32'h0, 32'h0, 1'b0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
